// File: rtl/datapath_pkg.sv
// Shared types for the two-stage datapath: control word layout, ALU/shifter opcodes, flag bit positions.
package datapath_pkg;

  localparam int unsigned DP_WIDTH = 16;
  localparam int unsigned DP_NREG  = 8;
  localparam int unsigned DP_RA    = $clog2(DP_NREG);
  localparam int unsigned DP_SA    = $clog2(DP_WIDTH);

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [3:0] {
    FS_A     = 4'h0,
    FS_INC   = 4'h1,
    FS_ADD   = 4'h2,
    FS_ADDC  = 4'h3,
    FS_ADDNB = 4'h4,
    FS_SUB   = 4'h5,
    FS_DEC   = 4'h6,
    FS_B     = 4'h7,
    FS_AND   = 4'h8,
    FS_OR    = 4'h9,
    FS_XOR   = 4'hA,
    FS_NOTA  = 4'hB
  } fs_e;

  typedef enum logic [2:0] {
    SH_PASS = 3'd0,
    SH_LSL  = 3'd1,
    SH_LSR  = 3'd2,
    SH_ASR  = 3'd3,
    SH_ROR  = 3'd4,
    SH_ROL  = 3'd5
  } sh_mode_e;

  typedef struct packed {
    logic [DP_RA-1:0] da;
    logic [DP_RA-1:0] aa;
    logic [DP_RA-1:0] ba;
    logic             rw;
    logic             mb;
    logic             md;
    fs_e              fs;
    sh_mode_e         sh_mode;
    logic [DP_SA-1:0] sh_amt;
  } cw_t;

endpackage

// File: rtl/pipelined_datapath_if.sv
// Control-word input and result output handshakes of the datapath.
interface pipelined_datapath_if #(
  parameter int unsigned WIDTH = datapath_pkg::DP_WIDTH
);
  import datapath_pkg::*;

  logic             cw_valid;
  logic             cw_ready;
  cw_t              cw;
  logic [WIDTH-1:0] const_b;
  logic [WIDTH-1:0] const_d;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [3:0]       res_flags;

  modport master (
    output cw_valid, cw, const_b, const_d, res_ready,
    input  cw_ready, res_valid, res_data, res_flags
  );

  modport slave (
    input  cw_valid, cw, const_b, const_d, res_ready,
    output cw_ready, res_valid, res_data, res_flags
  );

endinterface

// File: rtl/barrel_shifter_p.sv
// Combinational barrel shifter for the B operand: pass/LSL/LSR/ASR/ROR/ROL, amount taken mod WIDTH.
module barrel_shifter_p
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DP_WIDTH,
  parameter int unsigned SA    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  input  sh_mode_e         mode,
  input  logic [SA-1:0]    amt,
  output logic [WIDTH-1:0] dout_c
);

  logic [2*WIDTH-1:0] dbl;

  // Rotates come from shifting a doubled copy of the word.
  always_comb begin
    dbl    = {din, din};
    dout_c = din;
    case (mode)
      SH_LSL:  dout_c = din << amt;
      SH_LSR:  dout_c = din >> amt;
      SH_ASR:  dout_c = WIDTH'($signed(din) >>> amt);
      SH_ROR:  dout_c = WIDTH'(dbl >> amt);
      SH_ROL:  dout_c = WIDTH'((dbl << amt) >> WIDTH);
      default: dout_c = din;
    endcase
  end

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage (EX, WB) register-file datapath with valid/ready handshakes.
// Build option DATAPATH_FORWARD_EN: bypass WB data into EX reads instead of stalling on RAW hazards.
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DP_WIDTH,
  parameter int unsigned NREG  = DP_NREG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_datapath_if.slave   bus,
  output logic [WIDTH-1:0]      a_data,
  output logic [WIDTH-1:0]      shifted_b,
  output logic [NREG*WIDTH-1:0] regs
);

  logic [WIDTH-1:0] rf [NREG];
  logic             wb_rw;
  logic [DP_RA-1:0] wb_da;

  cw_t              cw;
  logic [WIDTH-1:0] b_rd;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH:0]   sum;
  logic             cin;
  logic             arith;
  logic [3:0]       flags_c;
  logic             stall;
  logic             accept;
  logic             commit;

  assign cw = bus.cw;

  // Operand read with either WB bypass or RAW-hazard stall.
  always_comb begin
    a_data = rf[cw.aa];
    b_rd   = rf[cw.ba];
    stall  = 1'b0;
`ifdef DATAPATH_FORWARD_EN
    if (bus.res_valid && wb_rw && (wb_da == cw.aa)) a_data = bus.res_data;
    if (bus.res_valid && wb_rw && (wb_da == cw.ba)) b_rd   = bus.res_data;
`else
    stall = bus.res_valid && wb_rw &&
            ((wb_da == cw.aa) || (!cw.mb && (wb_da == cw.ba)));
`endif
  end

  assign b_sel = cw.mb ? bus.const_b : b_rd;

  barrel_shifter_p #(.WIDTH(WIDTH), .SA(DP_SA)) u_shift (
    .din    (b_sel),
    .mode   (cw.sh_mode),
    .amt    (cw.sh_amt),
    .dout_c (shifted_b)
  );

  // ALU: arithmetic ops share one adder, A + b_op + cin.
  always_comb begin
    b_op  = '0;
    cin   = 1'b0;
    arith = 1'b0;
    alu_y = a_data;
    case (cw.fs)
      FS_A:     alu_y = a_data;
      FS_INC:   begin arith = 1'b1; cin = 1'b1; end
      FS_ADD:   begin arith = 1'b1; b_op = shifted_b; end
      FS_ADDC:  begin arith = 1'b1; b_op = shifted_b; cin = 1'b1; end
      FS_ADDNB: begin arith = 1'b1; b_op = ~shifted_b; end
      FS_SUB:   begin arith = 1'b1; b_op = ~shifted_b; cin = 1'b1; end
      FS_DEC:   begin arith = 1'b1; b_op = '1; end
      FS_B:     alu_y = shifted_b;
      FS_AND:   alu_y = a_data & shifted_b;
      FS_OR:    alu_y = a_data | shifted_b;
      FS_XOR:   alu_y = a_data ^ shifted_b;
      FS_NOTA:  alu_y = ~a_data;
      default:  alu_y = shifted_b;
    endcase
    sum = {1'b0, a_data} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    if (arith) alu_y = sum[WIDTH-1:0];

    flags_c         = '0;
    flags_c[FLAG_V] = arith && (a_data[WIDTH-1] == b_op[WIDTH-1]) &&
                      (alu_y[WIDTH-1] != a_data[WIDTH-1]);
    flags_c[FLAG_C] = arith && sum[WIDTH];
    flags_c[FLAG_N] = alu_y[WIDTH-1];
    flags_c[FLAG_Z] = (alu_y == '0);
  end

  assign bus.cw_ready = (!bus.res_valid || bus.res_ready) && !stall;
  assign accept       = bus.cw_valid && bus.cw_ready;
  assign commit       = bus.res_valid && bus.res_ready;

  // WB stage: reload on accept, otherwise empty on commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_flags <= '0;
      wb_rw         <= 1'b0;
      wb_da         <= '0;
    end else if (accept) begin
      bus.res_valid <= 1'b1;
      bus.res_data  <= cw.md ? bus.const_d : alu_y;
      bus.res_flags <= flags_c;
      wb_rw         <= cw.rw;
      wb_da         <= cw.da;
    end else if (commit) begin
      bus.res_valid <= 1'b0;
    end
  end

  // Register file write happens only when the WB entry is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (commit && wb_rw) begin
      rf[wb_da] <= bus.res_data;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_regs
    assign regs[g*WIDTH +: WIDTH] = rf[g];
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Directed self-checking bench for pipelined_datapath (default or DATAPATH_FORWARD_EN build).
module tb_pipelined_datapath;
  import datapath_pkg::*;

  localparam int unsigned W = 16;
`ifdef DATAPATH_FORWARD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [W-1:0]   a_data;
  logic [W-1:0]   shifted_b;
  logic [8*W-1:0] regs;
  int             checks = 0;
  int             passed = 0;

  always #5 clk = ~clk;

  pipelined_datapath_if #(.WIDTH(W)) bus ();

  pipelined_datapath #(.WIDTH(W), .NREG(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .a_data    (a_data),
    .shifted_b (shifted_b),
    .regs      (regs)
  );

  function automatic logic [W-1:0] rd(input int i);
    return regs[i*W +: W];
  endfunction

  function automatic cw_t mk(input logic [DP_RA-1:0] da, input logic [DP_RA-1:0] aa,
                             input logic [DP_RA-1:0] ba, input logic rw, input logic mb,
                             input logic md, input fs_e fs, input sh_mode_e sh,
                             input logic [DP_SA-1:0] amt);
    cw_t c;
    c.da = da; c.aa = aa; c.ba = ba; c.rw = rw; c.mb = mb; c.md = md;
    c.fs = fs; c.sh_mode = sh; c.sh_amt = amt;
    return c;
  endfunction

  task automatic idle();
    bus.cw_valid = 1'b0;
    bus.cw       = '0;
    bus.const_b  = '0;
    bus.const_d  = '0;
  endtask

  // Offer a control word and return at posedge+1 after it is accepted.
  task automatic send(input cw_t c, input logic [W-1:0] cb, input logic [W-1:0] cd);
    bit ok = 0;
    bus.cw = c; bus.const_b = cb; bus.const_d = cd; bus.cw_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cw_ready) begin ok = 1; break; end
    end
    checks++;
    if (!ok) $display("FAIL send_accept: cw_ready never rose within 10 cycles");
    else passed++;
    @(posedge clk); #1;
    bus.cw_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.res_valid) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!ok) $display("FAIL drain: res_valid stuck at 1 for 10 cycles");
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.res_ready = 1'b1; idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid: got %0b want 0", bus.res_valid); else passed++;
    checks++; if (bus.res_data !== 16'h0) $display("FAIL reset_res_data: got %h want 0000", bus.res_data); else passed++;
    checks++; if (bus.res_flags !== 4'h0) $display("FAIL reset_res_flags: got %b want 0000", bus.res_flags); else passed++;
    checks++; if (regs !== '0) $display("FAIL reset_regs: got %h want 0", regs); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.cw_ready !== 1'b1) $display("FAIL reset_cw_ready: got %0b want 1", bus.cw_ready); else passed++;
  endtask

  task automatic test_const_write();
    bus.cw = mk(3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, FS_A, SH_PASS, 4'd0);
    bus.const_d = 16'h1234; bus.cw_valid = 1'b1;
    @(negedge clk);
    checks++; if (bus.cw_ready !== 1'b1) $display("FAIL const_cw_ready: got %0b want 1", bus.cw_ready); else passed++;
    @(posedge clk); #1;
    bus.cw_valid = 1'b0;
    checks++; if (bus.res_valid !== 1'b1) $display("FAIL const_res_valid: got %0b want 1", bus.res_valid); else passed++;
    checks++; if (bus.res_data !== 16'h1234) $display("FAIL const_res_data: got %h want 1234", bus.res_data); else passed++;
    checks++; if (bus.res_flags !== 4'b0001) $display("FAIL const_flags: got %b want 0001", bus.res_flags); else passed++;
    checks++; if (rd(3) !== 16'h0) $display("FAIL const_r3_early: got %h want 0000", rd(3)); else passed++;
    @(posedge clk); #1;
    checks++; if (rd(3) !== 16'h1234) $display("FAIL const_r3: got %h want 1234", rd(3)); else passed++;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL const_res_valid_off: got %0b want 0", bus.res_valid); else passed++;
  endtask

  task automatic test_alu();
    send(mk(3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, FS_A, SH_PASS, 4'd0), 16'h0, 16'h7FFF);
    send(mk(3'd2, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, FS_A, SH_PASS, 4'd0), 16'h0, 16'h0001);
    drain();
    bus.cw = mk(3'd4, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, FS_ADD, SH_PASS, 4'd0);
    bus.cw_valid = 1'b1;
    @(negedge clk);
    checks++; if (a_data !== 16'h7FFF) $display("FAIL add_a_data: got %h want 7fff", a_data); else passed++;
    checks++; if (shifted_b !== 16'h0001) $display("FAIL add_shifted_b: got %h want 0001", shifted_b); else passed++;
    checks++; if (bus.cw_ready !== 1'b1) $display("FAIL add_cw_ready: got %0b want 1", bus.cw_ready); else passed++;
    @(posedge clk); #1;
    bus.cw_valid = 1'b0;
    checks++; if (bus.res_data !== 16'h8000) $display("FAIL add_res_data: got %h want 8000", bus.res_data); else passed++;
    checks++; if (bus.res_flags !== 4'b1010) $display("FAIL add_flags: got %b want 1010", bus.res_flags); else passed++;
    drain();
    checks++; if (rd(4) !== 16'h8000) $display("FAIL add_r4: got %h want 8000", rd(4)); else passed++;
    // r3 - 0x1234 = 0, carry out set
    send(mk(3'd0, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, FS_SUB, SH_PASS, 4'd0), 16'h1234, 16'h0);
    checks++; if (bus.res_data !== 16'h0000) $display("FAIL sub_res_data: got %h want 0000", bus.res_data); else passed++;
    checks++; if (bus.res_flags !== 4'b0101) $display("FAIL sub_flags: got %b want 0101", bus.res_flags); else passed++;
    send(mk(3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, FS_DEC, SH_PASS, 4'd0), 16'h0, 16'h0);
    checks++; if (bus.res_data !== 16'hFFFF) $display("FAIL dec_res_data: got %h want ffff", bus.res_data); else passed++;
    checks++; if (bus.res_flags !== 4'b0010) $display("FAIL dec_flags: got %b want 0010", bus.res_flags); else passed++;
    drain();
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    send(mk(3'd1, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, FS_A, SH_PASS, 4'd0), 16'h0, 16'h0005);
    bus.cw = mk(3'd1, 3'd1, 3'd0, 1'b1, 1'b1, 1'b0, FS_INC, SH_PASS, 4'd0);
    bus.cw_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cw_ready) break;
      stalls++;
    end
    checks++; if (stalls != EXP_STALL) $display("FAIL b2b_stalls: got %0d want %0d", stalls, EXP_STALL); else passed++;
    checks++; if (a_data !== 16'h0005) $display("FAIL b2b_a_data: got %h want 0005", a_data); else passed++;
    @(posedge clk); #1;
    bus.cw_valid = 1'b0;
    checks++; if (bus.res_data !== 16'h0006) $display("FAIL b2b_res_data: got %h want 0006", bus.res_data); else passed++;
    checks++; if (bus.res_flags !== 4'b0000) $display("FAIL b2b_flags: got %b want 0000", bus.res_flags); else passed++;
    drain();
    checks++; if (rd(1) !== 16'h0006) $display("FAIL b2b_r1: got %h want 0006", rd(1)); else passed++;
  endtask

  task automatic test_shift();
    logic [2:0]  md_t  [7] = '{3'd3, 3'd4, 3'd4, 3'd1, 3'd2, 3'd5, 3'd6};
    logic [3:0]  amt_t [7] = '{4'd1, 4'd4, 4'(W), 4'd1, 4'd15, 4'd4, 4'd3};
    logic [15:0] exp_t [7] = '{16'hC000, 16'h1800, 16'h8001, 16'h0002, 16'h0001, 16'h0018, 16'h8001};
    bus.cw_valid = 1'b0;
    bus.const_b  = 16'h8001;
    for (int i = 0; i < 7; i++) begin
      bus.cw = mk(3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, FS_B, sh_mode_e'(md_t[i]), amt_t[i]);
      #1;
      checks++;
      if (shifted_b !== exp_t[i])
        $display("FAIL shift_%0d: mode %0d amt %0d got %h want %h", i, md_t[i], amt_t[i], shifted_b, exp_t[i]);
      else passed++;
    end
    // RW=0 result passes through WB without a register write
    send(mk(3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, FS_B, SH_ASR, 4'd1), 16'h8001, 16'h0);
    checks++; if (bus.res_data !== 16'hC000) $display("FAIL shift_res_data: got %h want c000", bus.res_data); else passed++;
    checks++; if (bus.res_flags !== 4'b0010) $display("FAIL shift_flags: got %b want 0010", bus.res_flags); else passed++;
    drain();
    checks++; if (rd(5) !== 16'h0) $display("FAIL rw0_r5: got %h want 0000", rd(5)); else passed++;
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    send(mk(3'd6, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, FS_A, SH_PASS, 4'd0), 16'h0, 16'hBEEF);
    bus.cw = mk(3'd7, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, FS_A, SH_PASS, 4'd0);
    bus.const_d = 16'h0077; bus.cw_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.cw_ready !== 1'b0) $display("FAIL bp_cw_ready_%0d: got %0b want 0", i, bus.cw_ready); else passed++;
      checks++; if (bus.res_data !== 16'hBEEF) $display("FAIL bp_res_data_%0d: got %h want beef", i, bus.res_data); else passed++;
      checks++; if (rd(6) !== 16'h0) $display("FAIL bp_r6_%0d: got %h want 0000", i, rd(6)); else passed++;
    end
    @(posedge clk); #1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.cw_ready !== 1'b1) $display("FAIL bp_release_ready: got %0b want 1", bus.cw_ready); else passed++;
    @(posedge clk); #1;
    bus.cw_valid = 1'b0;
    checks++; if (rd(6) !== 16'hBEEF) $display("FAIL bp_r6: got %h want beef", rd(6)); else passed++;
    checks++; if (bus.res_data !== 16'h0077) $display("FAIL bp_next_data: got %h want 0077", bus.res_data); else passed++;
    checks++; if (rd(7) !== 16'h0) $display("FAIL bp_r7_early: got %h want 0000", rd(7)); else passed++;
    @(posedge clk); #1;
    checks++; if (rd(7) !== 16'h0077) $display("FAIL bp_r7: got %h want 0077", rd(7)); else passed++;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL bp_res_valid_off: got %0b want 0", bus.res_valid); else passed++;
  endtask

  task automatic test_reset_midstream();
    bus.res_ready = 1'b0;
    send(mk(3'd2, 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, FS_A, SH_PASS, 4'd0), 16'h0, 16'hAAAA);
    checks++; if (bus.res_valid !== 1'b1) $display("FAIL mid_res_valid_pre: got %0b want 1", bus.res_valid); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL mid_res_valid: got %0b want 0", bus.res_valid); else passed++;
    checks++; if (bus.res_data !== 16'h0) $display("FAIL mid_res_data: got %h want 0000", bus.res_data); else passed++;
    checks++; if (regs !== '0) $display("FAIL mid_regs: got %h want 0", regs); else passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (regs !== '0) $display("FAIL mid_regs_after: got %h want 0", regs); else passed++;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL mid_res_valid_after: got %0b want 0", bus.res_valid); else passed++;
    checks++; if (bus.cw_ready !== 1'b1) $display("FAIL mid_cw_ready: got %0b want 1", bus.cw_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_const_write();
    test_alu();
    test_back_to_back();
    test_shift();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
